// File: rtl/mem_defs.sv
// Shared L1 mempipe types: address/way/set types, the arbiter op
// type and issued-packet layout, plus arbiter sizing constants.
package mem_defs;

   localparam int MEMPIPE_ARB_NUM_REQ     = 4;
   localparam int MEMPIPE_STARVE_LIMIT    = 16;
   localparam int MEMPIPE_CONFLICT_STAGES = 3;

   localparam int PADDR_W   = 40;
   localparam int L1_WAYS   = 4;
   localparam int L1_SET_LO = 6;
   localparam int L1_SET_HI = 11;

   typedef logic [PADDR_W-1:0]         t_paddr;
   typedef logic [$clog2(L1_WAYS)-1:0] t_l1_way;
   typedef logic [L1_SET_HI:L1_SET_LO] t_l1_set;

   typedef enum logic [1:0] {
      ARB_FILL,
      ARB_EVICT,
      ARB_STORE,
      ARB_LOAD
   } t_arb_type;

   typedef struct packed {
      t_arb_type arb_type;
      t_l1_way   arb_way;
      t_paddr    paddr;
      logic      wr;
   } t_mempipe_arb;

   typedef struct packed {
      logic    vld;
      t_l1_set set_idx;
   } t_conflict_ent;

   function automatic t_l1_set l1_set_of(input t_paddr pa);
      return pa[L1_SET_HI:L1_SET_LO];
   endfunction

endpackage

// File: rtl/l1_mempipe_arb_rr_pick.sv
// Round-robin picker: one-hot select of the first set bit at or after ptr.
// Ports: req (request vector), ptr (start index), pick (one-hot result).
module rr_pick #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick
);

   always_comb begin
      logic found;
      int   idx;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_mempipe_arb.sv
// L1 mempipe arbiter: picks one MM0 request per cycle (FILL first, RR
// otherwise, starvation override), blocks same-set hazards against
// in-flight writes, registers the issued op as the MM1 packet.
// Ports: clk/reset; per-requester vld/paddr/way/wr; pipe_stall;
// req_gnt_mm0 (comb one-hot); arb_vld_mm1/arb_pkt_mm1; starve_any.
module l1_mempipe_arb
   import mem_defs::*;
#(
   parameter int NUM_REQ         = MEMPIPE_ARB_NUM_REQ,
   parameter int STARVE_LIMIT    = MEMPIPE_STARVE_LIMIT,
   parameter int CONFLICT_STAGES = MEMPIPE_CONFLICT_STAGES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_vld_mm0,
   input  t_paddr [NUM_REQ-1:0]   req_paddr_mm0,
   input  t_l1_way [NUM_REQ-1:0]  req_way_mm0,
   input  logic [NUM_REQ-1:0]     req_wr_mm0,
   input  logic                   pipe_stall,
   output logic [NUM_REQ-1:0]     req_gnt_mm0,
   output logic                   arb_vld_mm1,
   output t_mempipe_arb           arb_pkt_mm1,
   output logic                   starve_any
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam int IW = $clog2(NUM_REQ);
   localparam int RN = NUM_REQ - 1;
   localparam int RW = (RN > 1) ? $clog2(RN) : 1;

   logic [CW-1:0] cnt_q [NUM_REQ];
   logic [CW-1:0] cnt_d [NUM_REQ];
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   t_conflict_ent [CONFLICT_STAGES-1:0] cfl_q, cfl_d;
   logic          arb_vld_q, arb_vld_d;
   t_mempipe_arb  arb_pkt_q, arb_pkt_d;
   logic          starve_any_q, starve_any_d;

   logic [NUM_REQ-1:0] conflict;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] starved;
   logic [NUM_REQ-1:0] gnt;
   logic [RN-1:0]      rr_vec;
   logic [RW-1:0]      rr_start;
   logic [IW-1:0]      gnt_idx;

   always_comb begin
      conflict = '0;
      elig     = '0;
      starved  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int k = 0; k < CONFLICT_STAGES; k++) begin
            if (cfl_q[k].vld &&
                cfl_q[k].set_idx == l1_set_of(req_paddr_mm0[i]))
               conflict[i] = 1'b1;
         end
         elig[i]    = req_vld_mm0[i] & ~pipe_stall & ~conflict[i];
         starved[i] = (cnt_q[i] == CW'(STARVE_LIMIT));
      end
   end

   // RR group covers indices 1..NUM_REQ-1; rr_ptr is kept in that range.
   assign rr_start = RW'(rr_ptr_q - IW'(1));

   rr_pick #(.N(RN)) u_rr_pick (
      .req  (elig[NUM_REQ-1:1]),
      .ptr  (rr_start),
      .pick (rr_vec)
   );

   // A starved requester owns the slot even when it cannot take it.
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      if (|starved) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && starved[i]) begin
               found  = 1'b1;
               gnt[i] = elig[i];
            end
         end
      end else if (elig[0]) begin
         gnt[0] = 1'b1;
      end else begin
         gnt = {rr_vec, 1'b0};
      end
      if (reset)
         gnt = '0;
   end

   assign req_gnt_mm0 = gnt;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i])
            gnt_idx = IW'(i);
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (|gnt[NUM_REQ-1:1])
         rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? IW'(1)
                                                  : gnt_idx + IW'(1);

      starve_any_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i] || !req_vld_mm0[i])
            cnt_d[i] = '0;
         else if (starved[i])
            cnt_d[i] = cnt_q[i];
         else
            cnt_d[i] = cnt_q[i] + CW'(1);
         if (cnt_d[i] == CW'(STARVE_LIMIT))
            starve_any_d = 1'b1;
      end

      // Shifts every cycle; a no-grant or read cycle inserts a bubble.
      cfl_d[0].vld     = (|gnt) & req_wr_mm0[gnt_idx];
      cfl_d[0].set_idx = l1_set_of(req_paddr_mm0[gnt_idx]);
      for (int k = 1; k < CONFLICT_STAGES; k++)
         cfl_d[k] = cfl_q[k-1];

      arb_vld_d = |gnt;
      arb_pkt_d = arb_pkt_q;
      if (|gnt) begin
         arb_pkt_d.arb_type = t_arb_type'(gnt_idx);
         arb_pkt_d.arb_way  = req_way_mm0[gnt_idx];
         arb_pkt_d.paddr    = req_paddr_mm0[gnt_idx];
         arb_pkt_d.wr       = req_wr_mm0[gnt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++)
            cnt_q[i] <= '0;
         rr_ptr_q     <= IW'(1);
         cfl_q        <= '0;
         arb_vld_q    <= 1'b0;
         arb_pkt_q    <= '0;
         starve_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            cnt_q[i] <= cnt_d[i];
         rr_ptr_q     <= rr_ptr_d;
         cfl_q        <= cfl_d;
         arb_vld_q    <= arb_vld_d;
         arb_pkt_q    <= arb_pkt_d;
         starve_any_q <= starve_any_d;
      end
   end

   assign arb_vld_mm1 = arb_vld_q;
   assign arb_pkt_mm1 = arb_pkt_q;
   assign starve_any  = starve_any_q;

endmodule

// File: tb/tb_l1_mempipe_arb.sv
// Directed-vector bench for l1_mempipe_arb plus a short random-traffic
// phase checking grant legality, set hazards and wait bounds.
module tb_l1_mempipe_arb;
   import mem_defs::*;

   localparam int BOUND = 4 * (16 + 3 + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    vld;
   t_paddr [3:0]  paddr;
   t_l1_way [3:0] way;
   logic [3:0]    wr;
   logic          stall;
   logic [3:0]    gnt;
   logic          arb_vld;
   t_mempipe_arb  pkt;
   logic          starve;

   int n_vec = 0;
   int n_err = 0;

   l1_mempipe_arb dut (
      .clk           (clk),
      .reset         (reset),
      .req_vld_mm0   (vld),
      .req_paddr_mm0 (paddr),
      .req_way_mm0   (way),
      .req_wr_mm0    (wr),
      .pipe_stall    (stall),
      .req_gnt_mm0   (gnt),
      .arb_vld_mm1   (arb_vld),
      .arb_pkt_mm1   (pkt),
      .starve_any    (starve)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic t_paddr pa(input int s, input int tag);
      return (t_paddr'(tag) << 12) | (t_paddr'(s) << L1_SET_LO);
   endfunction

   logic [3:0] t1_exp [4];
   logic       rv [4];
   int         rs [4];
   int         wt [4];
   logic       hv [3];
   int         hs [3];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      t1_exp[0] = 4'b0100;
      t1_exp[1] = 4'b1000;
      t1_exp[2] = 4'b0100;
      t1_exp[3] = 4'b1000;
      reset = 1'b1;
      vld   = 4'hf;
      wr    = '0;
      paddr = '0;
      way   = '0;
      stall = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_vld", 64'(arb_vld), 64'(0));
      chk("rst_pkt", 64'(pkt), 64'(0));
      chk("rst_starve", 64'(starve), 64'(0));

      // 1: STORE/LOAD alternate under round robin
      tick();
      reset    = 1'b0;
      vld      = 4'b1100;
      paddr[2] = pa(1, 1);
      paddr[3] = pa(2, 1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t1_gnt", 64'(gnt), 64'(t1_exp[c]));
         chk("t1_vld", 64'(arb_vld), 64'(c != 0));
         if (c > 0)
            chk("t1_type", 64'(pkt.arb_type), 64'((c % 2 == 1) ? 2 : 3));
         tick();
      end
      vld = '0;
      @(negedge clk);
      chk("t1_gnt_idle", 64'(gnt), 64'(0));
      chk("t1_last_vld", 64'(arb_vld), 64'(1));
      chk("t1_last_type", 64'(pkt.arb_type), 64'(3));
      tick();
      @(negedge clk);
      chk("t1_idle_vld", 64'(arb_vld), 64'(0));
      chk("t1_hold_type", 64'(pkt.arb_type), 64'(3));

      // 2a: FILL write to set 5 blocks LOAD to set 5 for 3 cycles
      tick();
      vld      = 4'b1001;
      paddr[0] = pa(5, 1);
      wr[0]    = 1'b1;
      way[0]   = 2'd2;
      paddr[3] = pa(5, 2);
      @(negedge clk);
      chk("t2_fill_gnt", 64'(gnt), 64'(4'b0001));
      tick();
      vld[0] = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("t2_load_blk", 64'(gnt), 64'(0));
         if (c == 1) begin
            chk("t2_pkt_type", 64'(pkt.arb_type), 64'(0));
            chk("t2_pkt_wr", 64'(pkt.wr), 64'(1));
            chk("t2_pkt_way", 64'(pkt.arb_way), 64'(2));
            chk("t2_pkt_pa", 64'(pkt.paddr), 64'(pa(5, 1)));
         end
         tick();
      end
      @(negedge clk);
      chk("t2_load_gnt", 64'(gnt), 64'(4'b1000));
      tick();
      vld = '0;
      tick();

      // 2b: LOAD to a different set is not blocked
      vld      = 4'b0001;
      paddr[0] = pa(5, 3);
      @(negedge clk);
      chk("t2b_fill_gnt", 64'(gnt), 64'(4'b0001));
      tick();
      vld      = 4'b1000;
      paddr[3] = pa(6, 3);
      @(negedge clk);
      chk("t2b_load_gnt", 64'(gnt), 64'(4'b1000));
      tick();
      vld = '0;
      tick();
      tick();
      tick();

      // 3: FILL hogs the pipe until LOAD starves
      vld      = 4'b1001;
      wr       = '0;
      paddr[0] = pa(1, 4);
      paddr[3] = pa(2, 4);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk("t3_fill_gnt", 64'(gnt), 64'(4'b0001));
         chk("t3_no_starve", 64'(starve), 64'(0));
         tick();
      end
      @(negedge clk);
      chk("t3_starve_gnt", 64'(gnt), 64'(4'b1000));
      chk("t3_starve_any", 64'(starve), 64'(1));
      tick();
      @(negedge clk);
      chk("t3_after_gnt", 64'(gnt), 64'(4'b0001));
      chk("t3_after_starve", 64'(starve), 64'(0));
      tick();
      vld = '0;
      tick();
      tick();

      // 4: stall with all requesters valid
      stall = 1'b1;
      vld   = 4'hf;
      for (int i = 0; i < 4; i++)
         paddr[i] = pa(8 + i, 5);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_stall_gnt", 64'(gnt), 64'(0));
         chk("t4_stall_vld", 64'(arb_vld), 64'(0));
         tick();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("t4_fill_first", 64'(gnt), 64'(4'b0001));
      chk("t4_vld_low", 64'(arb_vld), 64'(0));
      tick();
      vld = '0;
      @(negedge clk);
      chk("t4_vld_high", 64'(arb_vld), 64'(1));
      chk("t4_type", 64'(pkt.arb_type), 64'(0));
      tick();
      tick();
      tick();
      tick();

      // 5: reset drops in-flight conflict tracking
      vld      = 4'b0001;
      paddr[0] = pa(5, 6);
      wr[0]    = 1'b1;
      @(negedge clk);
      chk("t5_fill_gnt", 64'(gnt), 64'(4'b0001));
      tick();
      reset    = 1'b1;
      vld      = 4'b1000;
      wr       = '0;
      paddr[3] = pa(5, 7);
      @(negedge clk);
      chk("t5_rst_gnt", 64'(gnt), 64'(0));
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t5_vld", 64'(arb_vld), 64'(0));
      chk("t5_pkt", 64'(pkt), 64'(0));
      chk("t5_starve", 64'(starve), 64'(0));
      chk("t5_load_gnt", 64'(gnt), 64'(4'b1000));
      tick();
      vld = '0;
      @(negedge clk);
      chk("t5_load_vld", 64'(arb_vld), 64'(1));
      chk("t5_load_type", 64'(pkt.arb_type), 64'(3));
      tick();
      tick();
      tick();
      tick();

      // 6: random traffic, hazard and latency checks
      for (int i = 0; i < 4; i++) begin
         rv[i] = 1'b0;
         rs[i] = 0;
         wt[i] = 0;
      end
      for (int k = 0; k < 3; k++) begin
         hv[k] = 1'b0;
         hs[k] = 0;
      end
      begin
         int  prev_idx;
         logic prev_g;
         prev_g   = 1'b0;
         prev_idx = 0;
         for (int cy = 0; cy < 600; cy++) begin
            logic [3:0] g;
            int         idx;
            logic       hz;
            for (int i = 0; i < 4; i++) begin
               if (!rv[i] && $urandom_range(2) == 0) begin
                  rv[i]    = 1'b1;
                  rs[i]    = int'($urandom_range(3));
                  wr[i]    = (i != 3) && ($urandom_range(1) == 1);
                  way[i]   = t_l1_way'($urandom_range(3));
                  paddr[i] = pa(rs[i], i);
                  wt[i]    = 0;
               end
               vld[i] = rv[i];
            end
            @(negedge clk);
            g = gnt;
            chk("r_onehot", 64'($onehot0(g)), 64'(1));
            chk("r_gnt_vld", 64'(g & ~vld), 64'(0));
            if (prev_g)
               chk("r_pkt_type", 64'(pkt.arb_type), 64'(prev_idx));
            idx = 0;
            for (int i = 0; i < 4; i++)
               if (g[i])
                  idx = i;
            if (|g) begin
               hz = 1'b0;
               for (int k = 0; k < 3; k++)
                  if (hv[k] && hs[k] == rs[idx])
                     hz = 1'b1;
               chk("r_hazard", 64'(hz), 64'(0));
               chk("r_latency", 64'(wt[idx] <= BOUND), 64'(1));
            end
            tick();
            hv[2] = hv[1];
            hs[2] = hs[1];
            hv[1] = hv[0];
            hs[1] = hs[0];
            hv[0] = (|g) && wr[idx];
            hs[0] = rs[idx];
            prev_g   = |g;
            prev_idx = idx;
            for (int i = 0; i < 4; i++) begin
               if (g[i])
                  rv[i] = 1'b0;
               else if (rv[i])
                  wt[i]++;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
